// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port external memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam int ST_IDLE_IDX   = 0;
  localparam int ST_ACCESS_IDX = 1;
  localparam int ST_TURN_IDX   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'(1 << ST_IDLE_IDX),
    ST_ACCESS = 3'(1 << ST_ACCESS_IDX),
    ST_TURN   = 3'(1 << ST_TURN_IDX)
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Grant select: data port first, unless fetch has waited out a full data burst.
module mem_bus_arbiter_arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_DATA_BURST = 3,
  parameter int BURST_W        = 2
) (
  input  logic               f_req_i,
  input  logic               d_req_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic               grant_o
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

  always_comb begin
    if (d_req_i && !(f_req_i && (burst_i == BURST_MAX))) grant_o = PORT_DATA;
    else                                                grant_o = PORT_FETCH;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external address/data bus between the fetch and data ports,
// running each transfer as ACC_CYC enable clocks followed by one turnaround clock.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ACC_CYC        = 2,
  parameter int MAX_DATA_BURST = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              read_en,
  output logic              write_en,
  output logic              bus_busy
);

  localparam int CNT_W   = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(ACC_CYC - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                port_q, port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                read_en_q, read_en_d;
  logic                write_en_q, write_en_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant;

  mem_bus_arbiter_arb_pick #(
    .MAX_DATA_BURST (MAX_DATA_BURST),
    .BURST_W        (BURST_W)
  ) u_arb_pick (
    .f_req_i (f_req),
    .d_req_i (d_req),
    .burst_i (burst_q),
    .grant_o (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      burst_q    <= '0;
      port_q     <= PORT_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      ack_q      <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      burst_q    <= burst_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      read_en_q  <= read_en_d;
      write_en_q <= write_en_d;
      ack_q      <= ack_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    burst_d    = burst_q;
    port_d     = port_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    read_en_d  = read_en_q;
    write_en_d = write_en_q;
    ack_d      = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (f_req || d_req) begin
          port_d = grant;
          addr_d = (grant == PORT_DATA) ? d_addr : f_addr;
          if (grant == PORT_DATA && d_we) begin
            wdata_d    = d_wdata;
            write_en_d = 1'b1;
          end else begin
            read_en_d = 1'b1;
          end
          // Burst count only tracks data grants that made a pending fetch wait.
          if (grant == PORT_DATA && f_req)
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
          else
            burst_d = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (read_en_q) begin
            if (port_q == PORT_DATA) d_rdata_d = data_in;
            else                     f_rdata_d = data_in;
          end
          read_en_d  = 1'b0;
          write_en_d = 1'b0;
          ack_d      = 1'b1;
          state_d    = ST_TURN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  assign f_ack    = ack_q && (port_q == PORT_FETCH);
  assign d_ack    = ack_q && (port_q == PORT_DATA);
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign addr_bus = addr_q;
  assign data_out = wdata_q;
  assign read_en  = read_en_q;
  assign write_en = write_en_q;
  assign bus_busy = state_q[ST_ACCESS_IDX] | state_q[ST_TURN_IDX];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: ACC_CYC=2 main instance plus an ACC_CYC=1 instance.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct packed {
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } d_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr;
  logic [7:0]  d_wdata;
  logic        f_ack, d_ack, read_en, write_en, bus_busy;
  logic [7:0]  f_rdata, d_rdata, data_out, data_in;
  logic [15:0] addr_bus;

  logic        g_f_req, g_d_req, g_d_we;
  logic [15:0] g_f_addr, g_d_addr;
  logic [7:0]  g_d_wdata;
  logic        g_f_ack, g_d_ack, g_read_en, g_write_en, g_bus_busy;
  logic [7:0]  g_f_rdata, g_d_rdata, g_data_out, g_data_in;
  logic [15:0] g_addr_bus;

  logic [7:0]  f_exp_q[$];
  d_exp_t      d_exp_q[$];
  logic [7:0]  last_rd;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h99;
  endfunction

  // Bus memory model; off-window reads return a poison byte.
  assign data_in   = read_en   ? mem_byte(addr_bus)   : 8'hEE;
  assign g_data_in = g_read_en ? mem_byte(g_addr_bus) : 8'hEE;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ACC_CYC(2), .MAX_DATA_BURST(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .addr_bus(addr_bus), .data_out(data_out), .data_in(data_in),
    .read_en(read_en), .write_en(write_en), .bus_busy(bus_busy)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ACC_CYC(1), .MAX_DATA_BURST(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .f_req(g_f_req), .f_addr(g_f_addr), .f_ack(g_f_ack), .f_rdata(g_f_rdata),
    .d_req(g_d_req), .d_we(g_d_we), .d_addr(g_d_addr), .d_wdata(g_d_wdata),
    .d_ack(g_d_ack), .d_rdata(g_d_rdata),
    .addr_bus(g_addr_bus), .data_out(g_data_out), .data_in(g_data_in),
    .read_en(g_read_en), .write_en(g_write_en), .bus_busy(g_bus_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard side: pop expectations as acks come out of the main instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_en || write_en) check("en_exclusive", 32'(read_en & write_en), 0);
      if (write_en && d_exp_q.size() != 0) check("data_out", 32'(data_out), 32'(d_exp_q[0].wdata));
      if (f_ack) begin
        check("f_ack_expected", 32'(f_exp_q.size() != 0), 1);
        if (f_exp_q.size() != 0) check("f_rdata", 32'(f_rdata), 32'(f_exp_q.pop_front()));
      end
      if (d_ack) begin
        check("d_ack_expected", 32'(d_exp_q.size() != 0), 1);
        if (d_exp_q.size() != 0) begin
          d_exp_t e;
          e = d_exp_q.pop_front();
          if (!e.we) begin
            check("d_rdata", 32'(d_rdata), 32'(e.rdata));
            last_rd = e.rdata;
          end else begin
            check("d_rdata_hold", 32'(d_rdata), 32'(last_rd));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic order_q[$];
    logic exp_order[5];
    int   dcyc, fcyc, n_d, a1, a2;

    rst_n = 1'b0;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    g_f_req = 1'b0; g_f_addr = '0; g_d_req = 1'b0; g_d_we = 1'b0; g_d_addr = '0; g_d_wdata = '0;
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({f_ack, d_ack, read_en, write_en, bus_busy}), 0);
    check("rst_addr", 32'(addr_bus), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_rdata", 32'({f_rdata, d_rdata}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch read
    f_addr = 16'hA845; f_req = 1'b1; f_exp_q.push_back(8'h74);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t1_write_en", 32'(write_en), 0);
      if (c < 3) begin
        check("t1_read_en", 32'(read_en), 1);
        check("t1_addr", 32'(addr_bus), 32'h0000A845);
        check("t1_busy", 32'(bus_busy), 1);
        check("t1_no_ack", 32'(f_ack), 0);
      end else begin
        check("t1_f_ack", 32'(f_ack), 1);
        check("t1_f_rdata", 32'(f_rdata), 32'h74);
        check("t1_read_off", 32'(read_en), 0);
        f_req = 1'b0;
      end
    end
    @(negedge clk);
    check("t1_ack_pulse", 32'(f_ack), 0);
    check("t1_idle_busy", 32'(bus_busy), 0);
    check("t1_addr_hold", 32'(addr_bus), 32'h0000A845);

    // Data write
    d_addr = 16'h0030; d_wdata = 8'h5A; d_we = 1'b1; d_req = 1'b1;
    d_exp_q.push_back('{we: 1'b1, wdata: 8'h5A, rdata: 8'h00});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t2_read_en", 32'(read_en), 0);
      if (c < 3) begin
        check("t2_write_en", 32'(write_en), 1);
        check("t2_data_out", 32'(data_out), 32'h5A);
        check("t2_addr", 32'(addr_bus), 32'h00000030);
      end else begin
        check("t2_d_ack", 32'(d_ack), 1);
        check("t2_write_off", 32'(write_en), 0);
        d_req = 1'b0; d_we = 1'b0;
      end
    end
    @(negedge clk);

    // Simultaneous requests: data first, fetch 4 clocks later
    f_addr = 16'h1234; f_req = 1'b1; f_exp_q.push_back(mem_byte(16'h1234));
    d_addr = 16'h0040; d_we = 1'b0; d_req = 1'b1;
    d_exp_q.push_back('{we: 1'b0, wdata: 8'h00, rdata: mem_byte(16'h0040)});
    dcyc = -1; fcyc = -1;
    for (int c = 1; c <= 20 && fcyc < 0; c++) begin
      @(negedge clk);
      if (d_ack) begin dcyc = c; d_req = 1'b0; end
      if (f_ack) begin fcyc = c; f_req = 1'b0; end
    end
    check("t3_d_first", 32'(dcyc), 3);
    check("t3_f_gap", 32'(fcyc - dcyc), 4);
    @(negedge clk);

    // Starvation guard: D,D,D,F,D
    exp_order = '{PORT_DATA, PORT_DATA, PORT_DATA, PORT_FETCH, PORT_DATA};
    f_addr = 16'h2000; f_req = 1'b1; f_exp_q.push_back(mem_byte(16'h2000));
    d_addr = 16'h0100; d_we = 1'b0; d_req = 1'b1;
    d_exp_q.push_back('{we: 1'b0, wdata: 8'h00, rdata: mem_byte(16'h0100)});
    n_d = 0;
    for (int c = 0; c < 80 && order_q.size() < 5; c++) begin
      @(negedge clk);
      if (f_ack) begin order_q.push_back(PORT_FETCH); f_req = 1'b0; end
      if (d_ack) begin
        order_q.push_back(PORT_DATA);
        n_d++;
        if (n_d < 4) begin
          d_addr = d_addr + 16'h1;
          d_exp_q.push_back('{we: 1'b0, wdata: 8'h00, rdata: mem_byte(d_addr)});
        end else begin
          d_req = 1'b0;
        end
      end
    end
    check("t4_grants", 32'(order_q.size()), 5);
    for (int i = 0; i < 5 && i < order_q.size(); i++)
      check("t4_order", 32'(order_q[i]), 32'(exp_order[i]));
    repeat (2) @(negedge clk);

    // Reset in cycle 1 of a fetch, then reissue
    f_addr = 16'h0ABC; f_req = 1'b1;
    @(negedge clk);
    check("t5_read_en_pre", 32'(read_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_en", 32'({read_en, write_en, bus_busy}), 0);
    check("t5_rst_addr", 32'(addr_bus), 0);
    check("t5_rst_ack", 32'({f_ack, d_ack}), 0);
    check("t5_rst_rdata", 32'({f_rdata, d_rdata}), 0);
    last_rd = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    f_exp_q.push_back(mem_byte(16'h0ABC));
    fcyc = -1;
    for (int c = 1; c <= 10 && fcyc < 0; c++) begin
      @(negedge clk);
      if (f_ack) begin fcyc = c; f_req = 1'b0; end
    end
    check("t5_reissue_lat", 32'(fcyc), 3);
    @(negedge clk);

    // ACC_CYC=1 back-to-back fetches
    g_f_addr = 16'h0000; g_f_req = 1'b1;
    a1 = -1; a2 = -1;
    for (int c = 1; c <= 20 && a2 < 0; c++) begin
      @(negedge clk);
      check("t6_no_write", 32'({g_write_en, g_d_ack}), 0);
      if (g_f_ack) begin
        if (a1 < 0) begin
          a1 = c;
          check("t6_rdata0", 32'(g_f_rdata), 32'(mem_byte(16'h0000)));
          g_f_addr = 16'h0001;
        end else begin
          a2 = c;
          check("t6_rdata1", 32'(g_f_rdata), 32'(mem_byte(16'h0001)));
          g_f_req = 1'b0;
        end
      end
    end
    check("t6_first_lat", 32'(a1), 2);
    check("t6_spacing", 32'(a2 - a1), 3);
    repeat (2) @(negedge clk);
    check("t6_idle", 32'({g_bus_busy, g_data_out, g_d_rdata}), 0);
    check("sb_drained", 32'(f_exp_q.size() + d_exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns the external 16-bit address / 8-bit data bus and shares it between two requesters.
  - Fetch port (f_*): instruction-fetch side of the CPU FSM, read-only.
  - Data port (d_*): RAM/ROM operand read and write-back states, read/write.
- Sequences each transfer as a fixed-length bus cycle with a turnaround clock.
- Drives read_en/write_en and captures read data, so the CPU FSM only runs a req/ack handshake.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- ACC_CYC, 2, clocks enables and address are held per transfer (≥1).
- MAX_DATA_BURST, 3, consecutive data grants allowed while fetch is pending before fetch is forced (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request, held until f_ack
- f_addr  in  ADDR_W  fetch address, stable while f_req
- f_ack  out  1  one-cycle fetch completion pulse
- f_rdata  out  DATA_W  fetched byte; valid with f_ack, held until the next f_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  read byte; valid with d_ack, held until the next read d_ack
- addr_bus  out  ADDR_W  bus address
- data_out  out  DATA_W  bus write data
- data_in  in  DATA_W  bus read data
- read_en  out  1  bus read enable
- write_en  out  1  bus write enable
- bus_busy  out  1  high in ACCESS and TURN

Behaviour:
- Reset values: all outputs 0; state IDLE; burst counter 0; access counter 0.
- FSM, one-hot: IDLE, ACCESS, TURN.
- IDLE:
  - If any req is high, pick a winner (rules below) and register addr_bus = winner address.
  - Data write: register data_out = d_wdata and set write_en=1.
  - Any read: set read_en=1.
  - Load access counter = ACC_CYC-1 and go to ACCESS.
  - If no req, stay in IDLE; all outputs hold, enables stay 0.
- ACCESS:
  - Enables and addr_bus are held and the counter decrements.
  - On the edge where the counter is 0:
    - read: capture data_in into the winner's rdata;
    - clear read_en/write_en;
    - assert the winner's ack;
    - go to TURN.
- TURN: one clock; ack=1 for exactly this cycle; bus enables 0; next state is IDLE.
- Latency: with the request sampled at edge E0:
  - enables are high for cycles 1..ACC_CYC;
  - ack and rdata are valid in cycle ACC_CYC+1.
  - Throughput: one transfer per ACC_CYC+2 clocks.
- Requester rule: req drops at the edge that samples ack. A req that is still high in IDLE is a new request.
- Arbitration:
  - Data port has priority.
  - Burst counter increments on each data grant made while f_req=1, saturating at MAX_DATA_BURST.
  - If both req are high and the counter equals MAX_DATA_BURST, fetch wins.
  - Counter clears on any fetch grant, and on a data grant made with f_req=0.
- Requests arriving during ACCESS/TURN wait; inputs are sampled only in IDLE. The winner's inputs are registered at grant, so later changes are ignored.
- read_en and write_en are never high together. addr_bus keeps its last value in IDLE.
- Reset mid-transfer: return to IDLE immediately and drop enables/ack. The transfer is lost and the requester reissues it. rdata registers clear to 0.

Decomposition:
- Shared package holds:
  - one-hot state constants and their index constants (IDLE/ACCESS/TURN);
  - ADDR_W/DATA_W defaults;
  - a port-select encoding (PORT_FETCH=0, PORT_DATA=1).
- One natural sub-module: arb_pick.
  - Inputs: f_req, d_req, burst count.
  - Output: grant select.
  - Purely combinational, so it can be unit-tested separately.

Test Plan:
- Single fetch read:
  - Stimulus: f_req=1, f_addr=16'hA845, data_in=8'h74, ACC_CYC=2.
  - Required: read_en=1 and addr_bus=A845 in cycles 1-2; f_ack in cycle 3 with f_rdata=8'h74; write_en stays 0.
- Data write:
  - Stimulus: d_req=1, d_we=1, d_addr=16'h0030, d_wdata=8'h5A.
  - Required: write_en=1 and data_out=5A for 2 cycles; d_ack in cycle 3; read_en stays 0.
- Simultaneous requests:
  - Stimulus: f_req and d_req (read, 16'h0040) high together.
  - Required: data served first; fetch ack follows exactly 4 clocks after d_ack.
- Starvation guard:
  - Stimulus: d_req held with continuous reissues, f_req held, MAX_DATA_BURST=3.
  - Required: grant order D,D,D,F,D…; f_ack after the 3rd d_ack.
- Reset mid-ACCESS:
  - Stimulus: rst_n=0 during cycle 1 of a read.
  - Required: read_en, f_ack and addr_bus go to 0 asynchronously; after release, state is IDLE and a reissued request completes normally.
- ACC_CYC=1 back-to-back fetches:
  - Stimulus: two back-to-back fetches to 16'h0000 and 16'h0001.
  - Required: acks 3 clocks apart; each f_rdata matches its data_in.
